// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters,
// data-first with a bounded data streak and a watchdog on unacknowledged accesses.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              err_o,
  output logic              busy_o
);
  localparam int SW = $clog2(MAX_D_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t        state;
  logic [SW-1:0] d_streak;
  logic [WW-1:0] wd;
  logic          d_win, expire;
  always_comb begin
    d_win    = d_req_i && !(if_req_i && d_streak == SW'(MAX_D_BURST));
    d_gnt_o  = state == IDLE && d_win;
    if_gnt_o = state == IDLE && if_req_i && !d_win;
    expire   = wd == WW'(TIMEOUT - 1);
  end
  assign mem_req_o = state != IDLE;
  assign busy_o    = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      d_streak    <= '0;
      wd          <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      if_valid_o  <= 1'b0;
      d_valid_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      d_valid_o  <= 1'b0;
      err_o      <= 1'b0;
      if (state == IDLE) begin
        if (d_gnt_o) begin
          state       <= BUSY_D;
          mem_we_o    <= d_we_i;
          mem_addr_o  <= d_addr_i;
          mem_wdata_o <= d_wdata_i;
          wd          <= '0;
          d_streak    <= !if_req_i ? '0 : d_streak == SW'(MAX_D_BURST) ? d_streak : d_streak + SW'(1);
        end else if (if_gnt_o) begin
          state       <= BUSY_IF;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= if_addr_i;
          mem_wdata_o <= '0;
          wd          <= '0;
          d_streak    <= '0;
        end
      end else if (mem_ready_i || expire) begin
        // completion takes precedence over a coincident watchdog expiry
        state      <= IDLE;
        err_o      <= !mem_ready_i;
        if_valid_o <= state == BUSY_IF;
        d_valid_o  <= state == BUSY_D;
        if (mem_ready_i && state == BUSY_IF) if_rdata_o <= mem_rdata_i;
        if (mem_ready_i && state == BUSY_D && !mem_we_o) d_rdata_o <= mem_rdata_i;
      end else begin
        wd <= wd + WW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAXB = 4;
  localparam int TO   = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, err, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_own, m_cyc, m_streak, last_gnt;
  logic        m_we, m_ifv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
  logic [9:0]  seq;
  int          ngr;
  logic        ip, dp, dw;
  logic [31:0] ia, da, dwd;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_valid_o(d_valid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cyc = 0; m_streak = 0; last_gnt = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_ifr = 0; m_dr = 0;
    m_ifv = 0; m_dv = 0; m_err = 0;
  endtask

  // one clock cycle: drive inputs, compare against the model, then advance the model
  task automatic step(input logic ir, input logic [31:0] iad, input logic dr, input logic dwe,
                      input logic [31:0] dad, input logic [31:0] dwdat, input logic rdy, input logic [31:0] rd);
    logic eg_d, eg_i;
    @(negedge clk);
    if_req = ir; if_addr = iad; d_req = dr; d_we = dwe; d_addr = dad; d_wdata = dwdat;
    mem_ready = rdy; mem_rdata = rd;
    #1;
    eg_d = m_own == 0 && dr && !(ir && m_streak == MAXB);
    eg_i = m_own == 0 && ir && !eg_d;
    chk("if_gnt", if_gnt, eg_i);
    chk("d_gnt", d_gnt, eg_d);
    chk("if_valid", if_valid, m_ifv);
    chk("d_valid", d_valid, m_dv);
    chk("err", err, m_err);
    chk("busy", busy, m_own != 0);
    chk("mem_req", mem_req, m_own != 0);
    if (m_own != 0) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    @(posedge clk);
    last_gnt = eg_d ? 2 : eg_i ? 1 : 0;
    m_ifv = 0; m_dv = 0; m_err = 0;
    if (m_own == 0) begin
      if (eg_d) begin
        m_own = 2; m_we = dwe; m_addr = dad; m_wdata = dwdat; m_cyc = 0;
        m_streak = ir ? (m_streak < MAXB ? m_streak + 1 : MAXB) : 0;
      end else if (eg_i) begin
        m_own = 1; m_we = 0; m_addr = iad; m_wdata = 0; m_cyc = 0; m_streak = 0;
      end
    end else begin
      m_cyc++;
      if (rdy) begin
        if (m_own == 1) begin m_ifr = rd; m_ifv = 1; end
        else begin if (!m_we) m_dr = rd; m_dv = 1; end
        m_own = 0;
      end else if (m_cyc == TO) begin
        m_err = 1;
        if (m_own == 1) m_ifv = 1; else m_dv = 1;
        m_own = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    model_reset();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {if_valid, d_valid, err}, 0);
    chk("rst_mem_regs", {mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    // single fetch
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("fetch_gnt_c0", last_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    chk("fetch_addr_c1", mem_addr, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_data", if_rdata, 32'h00500093);
    // store then load
    step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    idle(1);
    chk("store_rdata_kept", d_rdata, 0);
    step(0, 0, 1, 0, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    idle(1);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);
    // wait states
    step(1, 32'h200, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001);
    idle(1);
    chk("wait_rdata", if_rdata, 32'hCAFE0001);
    // watchdog expiry, then ready coincident with expiry
    step(0, 0, 1, 0, 32'h80, 0, 0, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_err_seen", m_err, 1);
    idle(1);
    chk("wd_rdata_kept", d_rdata, 32'hDEADBEEF);
    step(0, 0, 1, 0, 32'h84, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("coincide_rdata", d_rdata, 32'h0BADF00D);
    // reset in the middle of a data access
    step(0, 0, 1, 0, 32'h90, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle(3);
    // priority and anti-starvation, both always requesting, immediate ready
    seq = 0; ngr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h1000 + i, 1, 0, 32'h2000 + i, 0, 1, $urandom);
      if (last_gnt != 0 && ngr < 10) begin seq = {seq[8:0], last_gnt == 2}; ngr++; end
    end
    chk("grant_order", seq, 10'b1111011110);
    idle(2);
    // random traffic
    ip = 0; dp = 0; dw = 0; ia = 0; da = 0; dwd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip) begin if ($urandom % 3 == 0) begin ip = 1; ia = $urandom; end end
      else if ($urandom % 20 == 0) ip = 0;
      if (!dp) begin if ($urandom % 2 == 0) begin dp = 1; dw = 1'($urandom); da = $urandom; dwd = $urandom; end end
      else if ($urandom % 20 == 0) dp = 0;
      step(ip, ia, dp, dw, da, dwd, $urandom % 3 == 0, $urandom);
      if (last_gnt == 1) ip = 0;
      if (last_gnt == 2) dp = 0;
    end
    idle(TO + 2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
